// File: rtl/uart_tester_pkg.sv
// Shared types and default sizing for the FPGA tester's UART-side blocks.
package uart_tester_pkg;

  typedef logic [7:0] byte_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

  localparam int UART_ARB_NREQ      = 2;
  localparam int UART_ARB_MAX_BURST = 16;

endpackage

// File: rtl/uart_tx_arb_rr_pick.sv
// Rotate-priority selector: first requester at or after ptr_i (mod N) wins.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] cand;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves a
    // value unassigned, which would otherwise infer a latch.
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr_i) + k) % N);
      if (!any_o && req_i[cand]) begin
        any_o          = 1'b1;
        onehot_o[cand] = 1'b1;
        idx_o          = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Packet-level round-robin arbiter sharing one UART TX byte interface
// between NREQ byte-stream requesters.
module uart_tx_arb
  import uart_tester_pkg::*;
#(
  parameter int NREQ      = UART_ARB_NREQ,
  parameter int MAX_BURST = UART_ARB_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic [NREQ-1:0]   grant,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t      state_q;
  logic [NREQ-1:0] grant_q;
  logic            busy_q;
  logic [IW-1:0]   owner_q;
  logic [IW-1:0]   rr_ptr_q;
  logic [IW-1:0]   rr_ptr_d;
  logic [CW-1:0]   beat_cnt_q;

  logic [NREQ-1:0] pick_onehot;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  byte_t           req_bytes [NREQ];
  logic            owning;
  logic            own_valid;
  logic            beat;
  logic            release_beat;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req_i    (req_valid),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) req_bytes[i] = req_data[8*i +: 8];
  end

  assign owning    = (state_q == ARB_OWN);
  assign own_valid = req_valid[owner_q];
  assign beat      = owning && own_valid && tx_ready;
  // The burst cap releases on the MAX_BURST-th beat, so beat_cnt never wraps.
  assign release_beat = beat && (req_last[owner_q] || (beat_cnt_q == CW'(MAX_BURST - 1)));
  assign rr_ptr_d  = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

  assign tx_valid  = owning && own_valid;
  assign tx_data   = owning ? req_bytes[owner_q] : '0;
  assign req_ready = grant_q & {NREQ{tx_ready}};
  assign grant     = grant_q;
  assign busy      = busy_q;

  // NOTE: all state here is sequential and uses non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            state_q    <= ARB_OWN;
            grant_q    <= pick_onehot;
            busy_q     <= 1'b1;
            owner_q    <= pick_idx;
            beat_cnt_q <= '0;
          end
        end
        ARB_OWN: begin
          // Release always passes through IDLE, giving one dead cycle between grants.
          if (release_beat) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= '0;
          end else if (beat) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Scoreboarded bench for uart_tx_arb: per-requester byte streams plus a
// transaction-level arbitration model checked every cycle.
module tb_uart_tx_arb;
  import uart_tester_pkg::*;

  localparam int N  = 2;
  localparam int MB = 4;

  typedef struct {
    byte_t data;
    logic  last;
    int    gap;
  } item_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid, req_last, req_ready, grant;
  logic [8*N-1:0] req_data;
  logic           tx_valid, tx_ready, busy;
  logic [7:0]     tx_data;

  item_t stim_q [N][$];
  item_t exp_q  [N][$];
  byte_t log_q  [$];
  logic  pat_q  [$];
  int    n_checks = 0;
  int    n_err    = 0;
  bit    rand_ready = 1'b0;
  bit    hold_ready = 1'b0;

  always #5 clk = ~clk;

  uart_tx_arb #(.NREQ(N), .MAX_BURST(MB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .tx_ready  (tx_ready),
    .grant     (grant),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  endtask

  task automatic push(input int r, input byte_t d, input logic l, input int gap);
    item_t it;
    it.data = d;
    it.last = l;
    it.gap  = gap;
    stim_q[r].push_back(it);
  endtask

  task automatic push_pkt(input int r, input byte_t first, input int len, input int gap);
    for (int b = 0; b < len; b++) push(r, first + byte_t'(b), b == len - 1, (b == 0) ? gap : 0);
  endtask

  function automatic bit pending();
    bit p = 1'b0;
    for (int r = 0; r < N; r++)
      if (stim_q[r].size() != 0 || exp_q[r].size() != 0) p = 1'b1;
    return p || (req_valid != '0) || (grant != '0);
  endfunction

  task automatic wait_done(input string name, input int budget);
    int cyc = 0;
    bit done = 1'b0;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      done = !pending();
    end
    n_checks++;
    if (!done) begin
      n_err++;
      $display("FAIL %s_drain: still pending after %0d cycles, expected all bytes sent", name, budget);
      finish_run();
    end
  endtask

  task automatic check_order(input string name, input byte_t exp[$]);
    check({name, "_len"}, log_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < log_q.size(); i++)
      check($sformatf("%s_byte%0d", name, i), log_q[i], exp[i]);
  endtask

  // Requester drivers: present one queued byte at a time, hold it until accepted.
  for (genvar g = 0; g < N; g++) begin : g_drv
    logic  v, l;
    byte_t d;
    item_t it;
    bit    acc;
    assign req_valid[g]       = v;
    assign req_last[g]        = l;
    assign req_data[8*g +: 8] = d;
    initial begin
      v = 1'b0;
      l = 1'b0;
      d = '0;
      forever begin
        @(posedge clk);
        #1;
        if (stim_q[g].size() == 0) begin
          v = 1'b0;
        end else begin
          it = stim_q[g].pop_front();
          exp_q[g].push_back(it);
          if (it.gap > 0) begin
            v = 1'b0;
            repeat (it.gap) begin
              @(posedge clk);
              #1;
            end
          end
          d   = it.data;
          l   = it.last;
          v   = 1'b1;
          acc = 1'b0;
          while (!acc) begin
            @(negedge clk);
            acc = req_ready[g];
            if (!acc) begin
              @(posedge clk);
              #1;
            end
          end
        end
      end
    end
  end

  initial begin : tx_sink
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (hold_ready)            tx_ready = 1'b0;
      else if (pat_q.size() > 0) tx_ready = pat_q.pop_front();
      else if (rand_ready)       tx_ready = ($urandom_range(0, 3) != 0);
      else                       tx_ready = 1'b1;
    end
  end

  // Reference model: owner is -1 when idle; grants are whole packets capped at MB bytes.
  initial begin : monitor
    int    m_owner;
    int    m_ptr;
    int    m_cnt;
    bit    xfer;
    item_t it;
    m_owner = -1;
    m_ptr   = 0;
    m_cnt   = 0;
    forever begin
      @(negedge clk);
      check("grant", grant, (m_owner < 0) ? 0 : (1 << m_owner));
      check("busy", busy, m_owner >= 0);
      check("tx_valid", tx_valid, (m_owner >= 0) && req_valid[m_owner]);
      check("tx_data", tx_data, (m_owner >= 0) ? req_data[8*m_owner +: 8] : 0);
      check("req_ready", req_ready, (m_owner >= 0 && tx_ready) ? (1 << m_owner) : 0);
      xfer = rst_n && (m_owner >= 0) && req_valid[m_owner] && tx_ready;
      if (xfer) begin
        n_checks++;
        if (exp_q[m_owner].size() == 0) begin
          n_err++;
          $display("FAIL sb_underflow: requester %0d sent %0h, expected nothing pending", m_owner, tx_data);
        end else begin
          it = exp_q[m_owner].pop_front();
          if (tx_data !== it.data) begin
            n_err++;
            $display("FAIL sb_data: requester %0d got %0h, expected %0h", m_owner, tx_data, it.data);
          end
        end
        log_q.push_back(tx_data);
      end
      if (!rst_n) begin
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
      end else if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          if (m_owner < 0 && req_valid[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        end
        m_cnt = 0;
      end else if (xfer) begin
        if (req_last[m_owner] || m_cnt == MB - 1) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  initial begin : stimulus
    int len;
    int waited;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_grant", grant, 0);
    check("reset_busy", busy, 0);
    check("reset_tx_valid", tx_valid, 0);

    // Contention: both start together, both queue a second packet back to back.
    log_q.delete();
    push_pkt(0, 8'h10, 2, 0);
    push_pkt(0, 8'h12, 2, 0);
    push_pkt(1, 8'h20, 2, 0);
    push_pkt(1, 8'h22, 2, 0);
    wait_done("contention", 200);
    check_order("contention", '{8'h10, 8'h11, 8'h20, 8'h21, 8'h12, 8'h13, 8'h22, 8'h23});

    // Single requester, then a tie that exposes rr_ptr=1.
    log_q.delete();
    push_pkt(0, 8'h41, 3, 0);
    wait_done("single", 200);
    check_order("single", '{8'h41, 8'h42, 8'h43});
    log_q.delete();
    push(0, 8'h91, 1'b1, 0);
    push(1, 8'h92, 1'b1, 0);
    wait_done("tie", 200);
    check_order("tie", '{8'h92, 8'h91});

    // Burst cap of 4 splits the 6-byte packet around req1's byte.
    log_q.delete();
    push_pkt(0, 8'h00, 6, 0);
    push(1, 8'hAA, 1'b1, 1);
    wait_done("burst_cap", 200);
    check_order("burst_cap", '{8'h00, 8'h01, 8'h02, 8'h03, 8'hAA, 8'h04, 8'h05});

    // Backpressure: arbitration cycle, then ready 1,0,0,1 during the packet.
    log_q.delete();
    pat_q = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    push_pkt(0, 8'h31, 3, 0);
    wait_done("backpressure", 200);
    check_order("backpressure", '{8'h31, 8'h32, 8'h33});

    // Owner gap: req1 idles 5 cycles mid-packet while req0 waits.
    log_q.delete();
    push(1, 8'h71, 1'b0, 0);
    push(1, 8'h72, 1'b0, 5);
    push(1, 8'h73, 1'b1, 0);
    push(0, 8'h81, 1'b1, 1);
    wait_done("owner_gap", 200);
    check_order("owner_gap", '{8'h71, 8'h72, 8'h73, 8'h81});

    // Reset after the 2nd of 4 bytes; ready held low so nothing is in flight.
    log_q.delete();
    push_pkt(1, 8'h50, 4, 0);
    push(0, 8'h60, 1'b1, 2);
    waited = 0;
    do begin
      @(posedge clk);
      waited++;
    end while (log_q.size() < 2 && waited < 100);
    check("reset_wait", log_q.size() >= 2, 1);
    hold_ready = 1'b1;
    #1 rst_n = 1'b0;
    @(posedge clk);
    hold_ready = 1'b0;
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midrst_grant", grant, 0);
    check("midrst_busy", busy, 0);
    check("midrst_tx_valid", tx_valid, 0);
    check("midrst_tx_data", tx_data, 0);
    @(negedge clk);
    check("midrst_rearb_grant", grant, 2'b01);
    wait_done("mid_reset", 200);
    check_order("mid_reset", '{8'h50, 8'h51, 8'h60, 8'h52, 8'h53});

    // Randomized packets, gaps and tx_ready.
    rand_ready = 1'b1;
    for (int r = 0; r < N; r++) begin
      for (int p = 0; p < 15; p++) begin
        len = $urandom_range(1, 7);
        for (int b = 0; b < len; b++)
          push(r, byte_t'($urandom), b == len - 1, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0);
      end
    end
    wait_done("random", 5000);
    rand_ready = 1'b0;
    repeat (2) @(negedge clk);
    finish_run();
  end

endmodule
